// File: rtl/sha_host_ctrl_if.sv
// Bundle of the stream, SHA-core control and digest-host signals seen by
// sha_host_ctrl. The controller attaches through the master modport; the
// environment (stream source, core, host) attaches through the slave modport.
//
// Handshake semantics:
//   - Stream: a word transfers on a rising clk edge where s_valid && s_ready.
//     The source holds s_data/s_last stable while s_valid is high and s_ready
//     is low.
//   - Core: core_run is a single-cycle pulse, raised only while core_ready is
//     high. core_done is a single-cycle pulse and core_digest is valid with it.
//   - Digest: digest is valid while digest_valid is high. The host consumes it
//     with digest_ack. digest_ack is ignored while digest_valid is low.
interface sha_host_ctrl_if #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int DIGEST_W    = 256
);
  logic                          s_valid;
  logic [WORD_W-1:0]             s_data;
  logic                          s_last;
  logic                          s_ready;
  logic                          core_ready;
  logic                          core_done;
  logic [DIGEST_W-1:0]           core_digest;
  logic                          core_run;
  logic                          core_first;
  logic [WORD_W*BLOCK_WORDS-1:0] core_block;
  logic [DIGEST_W-1:0]           digest;
  logic                          digest_valid;
  logic                          digest_ack;
  logic                          busy;
  logic                          err;

  // Controller side.
  modport master (
    input  s_valid, s_data, s_last, core_ready, core_done, core_digest, digest_ack,
    output s_ready, core_run, core_first, core_block, digest, digest_valid, busy, err
  );

  // Environment side: stream source, SHA core and digest consumer.
  modport slave (
    output s_valid, s_data, s_last, core_ready, core_done, core_digest, digest_ack,
    input  s_ready, core_run, core_first, core_block, digest, digest_valid, busy, err
  );
endinterface

// File: rtl/sha_host_ctrl.sv
// Host-side requester for the SHA core. It packs 32-bit stream words into a
// 512-bit block, launches the core once per block, and chains the blocks of
// one message. After the final block it captures the digest and holds it
// until the host acknowledges it.
module sha_host_ctrl #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int DIGEST_W    = 256,
  parameter int TIMEOUT     = 127
) (
  input  logic            clk,
  input  logic            rst,
  sha_host_ctrl_if.master bus,
  output logic [2:0]      state_dbg_o
);

  localparam int BLOCK_W = WORD_W * BLOCK_WORDS;
  localparam int WCNT_W  = $clog2(BLOCK_WORDS);
  localparam int TCNT_W  = 7;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                last_flag_q;
  logic                first_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [BLOCK_W-1:0]  block_q;
  logic [DIGEST_W-1:0] digest_q;
  logic                digest_valid_q;
  logic                err_q;

  logic                accept;
  logic                block_full;

  // Stream acceptance and end-of-block detection.
  always_comb begin
    accept     = 1'b0;
    block_full = 1'b0;
    accept     = bus.s_valid && (state_q == ST_FILL) && !rst;
    block_full = (wcnt_q == WCNT_W'(BLOCK_WORDS - 1));
  end

  // Control FSM with its datapath registers. Word 0 of a block sits in the
  // top word of the block buffer. The buffer is written only in FILL, so it
  // stays stable while the core works on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_FILL;
      wcnt_q         <= '0;
      last_flag_q    <= 1'b0;
      first_q        <= 1'b1;
      tcnt_q         <= '0;
      block_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              if (wcnt_q == WCNT_W'(BLOCK_WORDS - 1 - i)) begin
                block_q[i*WORD_W +: WORD_W] <= bus.s_data;
              end
            end
            if (block_full) begin
              wcnt_q      <= '0;
              last_flag_q <= bus.s_last;
              state_q     <= ST_LAUNCH;
            end else begin
              wcnt_q <= wcnt_q + WCNT_W'(1);
              // A message must end on a block boundary. Padding is done upstream.
              if (bus.s_last) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end
          end
        end
        ST_LAUNCH: begin
          // core_run is raised in this cycle only when core_ready is high.
          // There is no timeout while the core is busy elsewhere.
          if (bus.core_ready) begin
            tcnt_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // core_done beats the timeout when both fall in the same cycle.
          // tcnt counts 0..TIMEOUT, so WAIT lasts at most TIMEOUT+1 cycles.
          if (bus.core_done) begin
            if (last_flag_q) begin
              digest_q       <= bus.core_digest;
              digest_valid_q <= 1'b1;
              state_q        <= ST_HOLD;
            end else begin
              first_q <= 1'b0;
              state_q <= ST_FILL;
            end
          end else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.digest_ack) begin
            digest_valid_q <= 1'b0;
            first_q        <= 1'b1;
            state_q        <= ST_FILL;
          end
        end
        ST_ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  // Outputs decoded from registered state. s_ready and core_run are held low
  // while rst is high, so no transfer or launch happens during reset.
  assign bus.s_ready      = (state_q == ST_FILL) && !rst;
  assign bus.core_run     = (state_q == ST_LAUNCH) && bus.core_ready && !rst;
  assign bus.core_first   = first_q;
  assign bus.core_block   = block_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy         = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign bus.err          = err_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_sha_host_ctrl.sv
// Testbench for sha_host_ctrl. A transaction-level model turns the accepted
// word stream into expected blocks and turns driven core completions into
// expected digests. A compare process checks every launch and every digest
// capture against the model. Directed scenarios add literal expectations.
module tb_sha_host_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  sha_host_ctrl_if bif ();

  sha_host_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif.master),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / model state ----------------
  int checks   = 0;
  int failures = 0;
  int run_cnt  = 0;

  logic [31:0]  mdl_words[$];
  logic         mdl_first;
  logic [511:0] exp_blk_q[$];
  logic         exp_first_q[$];
  logic         exp_last_q[$];
  logic [255:0] exp_dig_q[$];
  logic         inflight;
  logic         infl_last;

  logic [511:0] run_block;
  logic         run_first;
  logic         track;
  logic         dv_prev;
  logic [2:0]   stall_state;

  localparam logic [255:0] DIG_A5 = {8{32'hA5A5A5A5}};
  localparam logic [255:0] DIG_11 = {8{32'h11111111}};
  localparam logic [255:0] DIG_5A = {8{32'h5A5A5A5A}};
  localparam logic [255:0] DIG_77 = {8{32'h77777777}};
  localparam logic [255:0] DIG_C3 = {8{32'hC3C3C3C3}};
  localparam logic [255:0] DIG_DE = {8{32'hDEADBEEF}};
  localparam logic [255:0] DIG_3C = {8{32'h3C3C3C3C}};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    mdl_words.delete();
    exp_blk_q.delete();
    exp_first_q.delete();
    exp_last_q.delete();
    exp_dig_q.delete();
    mdl_first = 1'b1;
    inflight  = 1'b0;
    infl_last = 1'b0;
  endtask

  // Every 16 accepted words form one block, word 0 on top. A message ending
  // off a block boundary yields no launch.
  task automatic model_accept(input logic [31:0] d, input logic l);
    logic [511:0] blk;
    mdl_words.push_back(d);
    if (mdl_words.size() == 16) begin
      blk = '0;
      for (int i = 0; i < 16; i++) blk = {blk[479:0], mdl_words[i]};
      exp_blk_q.push_back(blk);
      exp_first_q.push_back(mdl_first);
      exp_last_q.push_back(l);
      mdl_first = l;
      mdl_words.delete();
    end else if (l) begin
      mdl_words.delete();
    end
  endtask

  // ---------------- driver tasks (entered just after a posedge) ----------------
  task automatic send_word(input logic [31:0] d, input logic l);
    int g;
    g = 0;
    bif.s_valid = 1'b1;
    bif.s_data  = d;
    bif.s_last  = l;
    forever begin
      @(negedge clk);
      if (bif.s_ready) begin
        model_accept(d, l);
        @(posedge clk); #1;
        break;
      end
      g++;
      if (g > 500) begin
        check("send_word_timeout", 1, 0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bif.s_valid = 1'b0;
    bif.s_last  = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] base, input int n, input int last_at, input bit toggle);
    for (int i = 0; i < n; i++) begin
      send_word(base + 32'(i), (i == last_at));
      if (toggle && i != n - 1) begin
        bif.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  // One-cycle core_done pulse. Only the in-flight final block yields a digest.
  task automatic drive_done(input logic [255:0] dig);
    bif.core_done   = 1'b1;
    bif.core_digest = dig;
    if (inflight) begin
      if (infl_last) exp_dig_q.push_back(dig);
      inflight = 1'b0;
    end
    @(posedge clk); #1;
    bif.core_done = 1'b0;
  endtask

  task automatic ack();
    bif.digest_ack = 1'b1;
    @(posedge clk); #1;
    bif.digest_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bif.s_valid     = 1'b0;
    bif.s_last      = 1'b0;
    bif.core_done   = 1'b0;
    bif.digest_ack  = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", bif.s_ready, 0);
    check("rst_core_run", bif.core_run, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard compare process ----------------
  initial begin : compare_proc
    track   = 1'b0;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bif.core_run) begin
          run_cnt++;
          if (exp_blk_q.size() == 0) begin
            check("unexpected_run", 1, 0);
          end else begin
            check("run_block", bif.core_block, exp_blk_q.pop_front());
            check("run_first", bif.core_first, exp_first_q.pop_front());
            infl_last = exp_last_q.pop_front();
            inflight  = 1'b1;
          end
          run_block = bif.core_block;
          run_first = bif.core_first;
          track     = 1'b1;
        end else if (track && bif.busy) begin
          check("block_stable", bif.core_block, run_block);
          check("first_stable", bif.core_first, run_first);
        end
        if (!bif.busy) track = 1'b0;
        if (bif.digest_valid && !dv_prev) begin
          if (exp_dig_q.size() == 0) check("unexpected_digest", 1, 0);
          else check("digest", bif.digest, exp_dig_q.pop_front());
        end
      end else begin
        track = 1'b0;
      end
      dv_prev = bif.digest_valid;
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    rst             = 1'b1;
    bif.s_valid     = 1'b0;
    bif.s_data      = '0;
    bif.s_last      = 1'b0;
    bif.core_ready  = 1'b1;
    bif.core_done   = 1'b0;
    bif.core_digest = '0;
    bif.digest_ack  = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", bif.s_ready, 0);
    check("reset_core_run", bif.core_run, 0);
    check("reset_busy", bif.busy, 0);
    check("reset_err", bif.err, 0);
    check("reset_digest_valid", bif.digest_valid, 0);
    check("reset_digest", bif.digest, 0);
    check("reset_core_block", bif.core_block, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_s_ready", bif.s_ready, 1);
    check("post_reset_first", bif.core_first, 1);
    @(posedge clk); #1;

    // Single-block message
    send_block(32'h1, 16, 15, 1'b0);
    @(negedge clk);
    check("t1_run", bif.core_run, 1);
    check("t1_first", bif.core_first, 1);
    check("t1_word0", bif.core_block[511:480], 32'h1);
    check("t1_word15", bif.core_block[31:0], 32'h10);
    check("t1_busy", bif.busy, 1);
    check("t1_s_ready", bif.s_ready, 0);
    repeat (64) @(posedge clk);
    #1;
    drive_done(DIG_A5);
    @(negedge clk);
    check("t1_dv", bif.digest_valid, 1);
    check("t1_digest", bif.digest, DIG_A5);
    check("t1_busy_hold", bif.busy, 0);
    check("t1_s_ready_hold", bif.s_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_dv_held", bif.digest_valid, 1);
    check("t1_runs", run_cnt, 1);
    @(posedge clk); #1;
    ack();
    @(negedge clk);
    check("t1_dv_after_ack", bif.digest_valid, 0);
    check("t1_s_ready_after_ack", bif.s_ready, 1);
    check("t1_digest_kept", bif.digest, DIG_A5);
    @(posedge clk); #1;

    // Two-block message
    send_block(32'h100, 16, -1, 1'b0);
    @(negedge clk);
    check("t2_run1", bif.core_run, 1);
    check("t2_first1", bif.core_first, 1);
    repeat (10) @(posedge clk);
    #1;
    drive_done(DIG_11);
    @(negedge clk);
    check("t2_s_ready_mid", bif.s_ready, 1);
    check("t2_dv_mid", bif.digest_valid, 0);
    check("t2_digest_mid", bif.digest, DIG_A5);
    check("t2_first_mid", bif.core_first, 0);
    @(posedge clk); #1;
    send_block(32'h110, 16, 15, 1'b0);
    @(negedge clk);
    check("t2_run2", bif.core_run, 1);
    check("t2_first2", bif.core_first, 0);
    check("t2_word0", bif.core_block[511:480], 32'h110);
    repeat (20) @(posedge clk);
    #1;
    drive_done(DIG_5A);
    @(negedge clk);
    check("t2_dv", bif.digest_valid, 1);
    check("t2_digest", bif.digest, DIG_5A);
    check("t2_runs", run_cnt, 3);
    @(posedge clk); #1;
    ack();

    // Backpressure: gapped stream, core not ready for 5 cycles
    bif.core_ready = 1'b0;
    send_block(32'hA000_0000, 16, 15, 1'b1);
    @(negedge clk);
    stall_state = state_dbg;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t3_no_run", bif.core_run, 0);
      check("t3_busy", bif.busy, 1);
      check("t3_s_ready", bif.s_ready, 0);
      check("t3_state_held", state_dbg, stall_state);
    end
    @(posedge clk); #1;
    bif.core_ready = 1'b1;
    @(negedge clk);
    check("t3_run", bif.core_run, 1);
    check("t3_word15", bif.core_block[31:0], 32'hA000_000F);
    @(posedge clk);
    @(negedge clk);
    check("t3_run_one_cycle", bif.core_run, 0);
    check("t3_busy_wait", bif.busy, 1);
    @(posedge clk); #1;
    drive_done(DIG_3C);
    @(negedge clk);
    check("t3_dv", bif.digest_valid, 1);
    @(posedge clk); #1;
    ack();

    // Early s_last on word 10
    send_block(32'h50, 10, 9, 1'b0);
    @(negedge clk);
    check("t4_err", bif.err, 1);
    check("t4_s_ready", bif.s_ready, 0);
    check("t4_no_run", bif.core_run, 0);
    @(posedge clk); #1;
    drive_done(DIG_77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_err_sticky", bif.err, 1);
    check("t4_dv", bif.digest_valid, 0);
    check("t4_busy", bif.busy, 0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("t4_err_cleared", bif.err, 0);
    @(posedge clk); #1;

    // Timeout with no core_done
    send_block(32'h700, 16, 15, 1'b0);
    @(negedge clk);
    check("t5_run", bif.core_run, 1);
    repeat (128) @(posedge clk);
    @(negedge clk);
    check("t5_err_at_limit", bif.err, 0);
    check("t5_busy_at_limit", bif.busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("t5_err", bif.err, 1);
    check("t5_busy_err", bif.busy, 0);
    check("t5_s_ready_err", bif.s_ready, 0);
    @(posedge clk); #1;
    do_reset();

    // core_done in the exact timeout cycle
    send_block(32'h800, 16, 15, 1'b0);
    @(negedge clk);
    check("t5b_run", bif.core_run, 1);
    repeat (128) @(posedge clk);
    #1;
    drive_done(DIG_C3);
    @(negedge clk);
    check("t5b_err", bif.err, 0);
    check("t5b_dv", bif.digest_valid, 1);
    check("t5b_digest", bif.digest, DIG_C3);
    @(posedge clk); #1;
    ack();

    // Reset during WAIT, late done ignored, new message
    send_block(32'h200, 16, 15, 1'b0);
    @(negedge clk);
    check("t6_run_old", bif.core_run, 1);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    drive_done(DIG_DE);
    @(negedge clk);
    check("t6_late_done_dv", bif.digest_valid, 0);
    check("t6_late_done_s_ready", bif.s_ready, 1);
    check("t6_late_done_err", bif.err, 0);
    check("t6_digest_cleared", bif.digest, 0);
    @(posedge clk); #1;
    send_block(32'h300, 16, 15, 1'b0);
    @(negedge clk);
    check("t6_run_new", bif.core_run, 1);
    check("t6_first", bif.core_first, 1);
    check("t6_word0", bif.core_block[511:480], 32'h300);
    repeat (20) @(posedge clk);
    #1;
    drive_done(DIG_A5);
    @(negedge clk);
    check("t6_dv", bif.digest_valid, 1);
    check("t6_digest", bif.digest, DIG_A5);
    @(posedge clk); #1;
    ack();
    @(negedge clk);

    // Final accounting
    check("total_runs", run_cnt, 8);
    check("blocks_left", exp_blk_q.size(), 0);
    check("digests_left", exp_dig_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
